// File: rtl/sram_seq_pkg.sv
// rtl/sram_seq_pkg.sv - shared types and constants for the SRAM word sequencer
package sram_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RSP
  } seq_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned SRAM_BYTES = 512;

endpackage

// File: rtl/sram_rr_arb2.sv
// rtl/sram_rr_arb2.sv - two-way round-robin arbiter, bit 0 = read, bit 1 = write
module sram_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  // Starts as "write granted last" so a read wins the first tie.
  logic last_wr_q;

  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) begin
      grant_o = last_wr_q ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_wr_q <= 1'b1;
    end else if (accept_i) begin
      last_wr_q <= grant_o[1];
    end
  end

endmodule

// File: rtl/sram_word_seq.sv
// rtl/sram_word_seq.sv - 32-bit word read/write requests to byte-serial 512x8 SRAM accesses
module sram_word_seq
  import sram_seq_pkg::*;
#(
  parameter int WIDTH_P = 32,
  parameter int SRAM_AW = 9
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic               rd_req_valid,
  output logic               rd_req_ready,
  input  logic [WIDTH_P-1:0] rd_req_addr,
  output logic               rd_rsp_valid,
  input  logic               rd_rsp_ready,
  output logic [WIDTH_P-1:0] rd_rsp_data,
  output logic [1:0]         rd_rsp_resp,
  input  logic               wr_req_valid,
  output logic               wr_req_ready,
  input  logic [WIDTH_P-1:0] wr_req_addr,
  input  logic [WIDTH_P-1:0] wr_req_data,
  input  logic [3:0]         wr_req_strb,
  output logic               wr_rsp_valid,
  input  logic               wr_rsp_ready,
  output logic [1:0]         wr_rsp_resp,
  output logic               sram_cen_n,
  output logic               sram_gwen_n,
  output logic [7:0]         sram_wen_n,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [7:0]         sram_d,
  input  logic [7:0]         sram_q
);

  seq_state_e         state_q;
  logic [2:0]         cnt_q;
  logic               is_wr_q;
  logic [SRAM_AW-3:0] word_q;
  logic [WIDTH_P-1:0] data_q;
  logic [3:0]         strb_q;

  logic [1:0]         grant;
  logic               idle;
  logic               accept;
  logic               sel_wr;
  logic               oob;
  logic [WIDTH_P-1:0] sel_addr;
  logic [SRAM_AW-1:0] next_addr_d;
  logic               unused_addr_lsbs;

  sram_rr_arb2 u_arb (
    .clk_i    (ACLK),
    .rst_ni   (ARESETN),
    .req_i    ({wr_req_valid, rd_req_valid}),
    .accept_i (accept),
    .grant_o  (grant)
  );

  assign idle             = (state_q == IDLE) && ARESETN;
  assign rd_req_ready     = idle & grant[0];
  assign wr_req_ready     = idle & grant[1];
  assign accept           = rd_req_ready | wr_req_ready;
  assign sel_wr           = grant[1];
  assign sel_addr         = sel_wr ? wr_req_addr : rd_req_addr;
  assign oob              = |sel_addr[WIDTH_P-1:SRAM_AW];
  assign unused_addr_lsbs = ^sel_addr[1:0];
  assign next_addr_d      = {word_q, cnt_q[1:0] + 2'd1};
  assign rd_rsp_data      = data_q;

  // SRAM outputs are registered one cycle ahead: while cnt_q == c the bus
  // presents byte c, and read data for byte c-1 is on sram_q.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      is_wr_q      <= 1'b0;
      word_q       <= '0;
      data_q       <= '0;
      strb_q       <= '0;
      rd_rsp_valid <= 1'b0;
      wr_rsp_valid <= 1'b0;
      rd_rsp_resp  <= RESP_OKAY;
      wr_rsp_resp  <= RESP_OKAY;
      sram_cen_n   <= 1'b1;
      sram_gwen_n  <= 1'b1;
      sram_wen_n   <= 8'hFF;
      sram_addr    <= '0;
      sram_d       <= '0;
    end else begin
      sram_cen_n  <= 1'b1;
      sram_gwen_n <= 1'b1;
      sram_wen_n  <= 8'hFF;
      case (state_q)
        IDLE: begin
          if (accept) begin
            is_wr_q <= sel_wr;
            word_q  <= sel_addr[SRAM_AW-1:2];
            cnt_q   <= '0;
            if (sel_wr) begin
              data_q <= wr_req_data;
              strb_q <= wr_req_strb;
            end
            if (oob) begin
              state_q <= RSP;
              if (sel_wr) begin
                wr_rsp_valid <= 1'b1;
                wr_rsp_resp  <= RESP_SLVERR;
              end else begin
                rd_rsp_valid <= 1'b1;
                rd_rsp_resp  <= RESP_SLVERR;
              end
            end else begin
              sram_addr <= {sel_addr[SRAM_AW-1:2], 2'b00};
              if (sel_wr) begin
                state_q     <= WR;
                sram_cen_n  <= ~wr_req_strb[0];
                sram_gwen_n <= 1'b0;
                sram_wen_n  <= 8'h00;
                sram_d      <= wr_req_data[7:0];
              end else begin
                state_q    <= RD;
                sram_cen_n <= 1'b0;
              end
            end
          end
        end
        RD: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q != 3'd0) begin
            data_q <= {sram_q, data_q[WIDTH_P-1:8]};
          end
          if (cnt_q < 3'd3) begin
            sram_cen_n <= 1'b0;
            sram_addr  <= next_addr_d;
          end
          if (cnt_q == 3'd4) begin
            state_q      <= RSP;
            rd_rsp_valid <= 1'b1;
            rd_rsp_resp  <= RESP_OKAY;
          end
        end
        WR: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q < 3'd3) begin
            data_q      <= data_q >> 8;
            strb_q      <= strb_q >> 1;
            sram_cen_n  <= ~strb_q[1];
            sram_gwen_n <= 1'b0;
            sram_wen_n  <= 8'h00;
            sram_addr   <= next_addr_d;
            sram_d      <= data_q[15:8];
          end else begin
            state_q      <= RSP;
            wr_rsp_valid <= 1'b1;
            wr_rsp_resp  <= RESP_OKAY;
          end
        end
        RSP: begin
          if ((is_wr_q && wr_rsp_ready) || (!is_wr_q && rd_rsp_ready)) begin
            rd_rsp_valid <= 1'b0;
            wr_rsp_valid <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
